// File: rtl/axi_inf_read_state_core_pkg.sv
// Shared types and AXI constants for the single-outstanding AXI4 read core.
package axi_inf_read_state_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
    localparam logic [1:0] RESP_OKAY     = 2'b00;

    localparam int ERR_RESP = 0;
    localparam int ERR_LAST = 1;
    localparam int ERR_ID   = 2;

endpackage

// File: rtl/axi_inf_read_state_core_beat_tracker.sv
// R-channel beat counter, final-beat compare and sticky per-burst error bits.
module axi_r_beat_tracker
    import axi_inf_read_state_core_pkg::*;
#(
    parameter int IDSIZE = 4,
    parameter int ID     = 0,
    parameter int LSIZE  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              beat,
    input  logic              rlast,
    input  logic [1:0]        rresp,
    input  logic [IDSIZE-1:0] rid,
    input  logic [LSIZE-1:0]  len,
    output logic              last,
    output logic              term,
    output logic [2:0]        err
);

    logic [LSIZE-1:0] beat_cnt;
    logic [2:0]       err_q;
    logic [2:0]       err_next;
    logic             at_len;

    assign at_len = (beat_cnt == len);
    assign last   = beat && at_len;
    // Either the expected final beat or an early rlast ends the burst.
    assign term   = beat && (at_len || rlast);
    assign err    = err_q;

    always_comb begin
        err_next = err_q;
        if (beat) begin
            if (rresp != RESP_OKAY)
                err_next[ERR_RESP] = 1'b1;
            if (rlast != at_len)
                err_next[ERR_LAST] = 1'b1;
            if (rid != IDSIZE'(ID))
                err_next[ERR_ID] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            err_q    <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
            err_q    <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
            err_q    <= err_next;
        end
    end

endmodule

// File: rtl/axi_inf_read_state_core.sv
// Single-outstanding AXI4 read master: IDLE accepts, ADDR issues AR,
// DATA forwards R beats with backpressure, DONE reports status for one cycle.
module axi_inf_read_state_core
    import axi_inf_read_state_core_pkg::*;
#(
    parameter int          IDSIZE = 4,
    parameter int          ID     = 0,
    parameter int          LSIZE  = 9,
    parameter int          ASIZE  = 29,
    parameter int          DSIZE  = 256,
    parameter logic [2:0]  ARSIZE = 3'b101
) (
    input  logic              axi_aclk,
    input  logic              axi_rst,
    input  logic              read_req,
    input  logic [LSIZE-1:0]  req_len,
    input  logic [ASIZE-1:0]  req_addr,
    output logic              req_resp,
    output logic              req_done,
    output logic [2:0]        req_err,
    output logic              busy,
    output logic [DSIZE-1:0]  odata,
    output logic              odata_vld,
    output logic              odata_last,
    input  logic              odata_ready,
    output logic [IDSIZE-1:0] axi_arid,
    output logic [ASIZE-1:0]  axi_araddr,
    output logic [LSIZE-1:0]  axi_arlen,
    output logic [2:0]        axi_arsize,
    output logic [1:0]        axi_arburst,
    output logic              axi_arlock,
    output logic [3:0]        axi_arcache,
    output logic [2:0]        axi_arprot,
    output logic [3:0]        axi_arqos,
    output logic              axi_arvalid,
    input  logic              axi_arready,
    input  logic [IDSIZE-1:0] axi_rid,
    input  logic [DSIZE-1:0]  axi_rdata,
    input  logic [1:0]        axi_rresp,
    input  logic              axi_rlast,
    input  logic              axi_rvalid,
    output logic              axi_rready
);

    state_t           state;
    state_t           state_next;
    logic [ASIZE-1:0] addr_q;
    logic [LSIZE-1:0] len_q;
    logic             resp_q;
    logic             accept;
    logic             ar_hs;
    logic             beat;
    logic             term;
    logic             last;
    logic [2:0]       err;

    assign accept = (state == ST_IDLE) && read_req;
    assign ar_hs  = (state == ST_ADDR) && axi_arready;
    assign beat   = axi_rvalid && axi_rready;

    always_comb begin
        state_next  = state;
        busy        = 1'b1;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        req_done    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (read_req)
                    state_next = ST_ADDR;
            end
            ST_ADDR: begin
                axi_arvalid = 1'b1;
                if (axi_arready)
                    state_next = ST_DATA;
            end
            ST_DATA: begin
                axi_rready = odata_ready;
                if (term)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                req_done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or posedge axi_rst) begin
        if (axi_rst) begin
            state  <= ST_IDLE;
            addr_q <= '0;
            len_q  <= '0;
            resp_q <= 1'b0;
        end else begin
            state  <= state_next;
            resp_q <= accept;
            if (accept) begin
                addr_q <= req_addr;
                len_q  <= req_len;
            end
        end
    end

    axi_r_beat_tracker #(
        .IDSIZE (IDSIZE),
        .ID     (ID),
        .LSIZE  (LSIZE)
    ) u_tracker (
        .clk    (axi_aclk),
        .rst    (axi_rst),
        .clear  (ar_hs || (state == ST_DONE)),
        .beat   (beat),
        .rlast  (axi_rlast),
        .rresp  (axi_rresp),
        .rid    (axi_rid),
        .len    (len_q),
        .last   (last),
        .term   (term),
        .err    (err)
    );

    // Data is gated by the transfer so the stream side sees zeros when idle.
    assign odata      = beat ? axi_rdata : '0;
    assign odata_vld  = beat;
    assign odata_last = last;
    assign req_resp   = resp_q;
    assign req_err    = req_done ? err : 3'b000;

    assign axi_arid    = IDSIZE'(ID);
    assign axi_araddr  = addr_q;
    assign axi_arlen   = len_q;
    assign axi_arsize  = ARSIZE;
    assign axi_arburst = BURST_INCR;
    assign axi_arlock  = 1'b0;
    assign axi_arcache = CACHE_DEFAULT;
    assign axi_arprot  = 3'b000;
    assign axi_arqos   = 4'b0000;

endmodule

// File: tb/tb_axi_inf_read_state_core.sv
// Randomized bench for axi_inf_read_state_core with a transaction-level reference model.
module tb_axi_inf_read_state_core;

    localparam int IDSIZE = 4;
    localparam int LSIZE  = 9;
    localparam int ASIZE  = 29;
    localparam int DSIZE  = 256;

    logic              axi_aclk = 1'b0;
    logic              axi_rst  = 1'b1;
    logic              read_req = 1'b0;
    logic [LSIZE-1:0]  req_len  = '0;
    logic [ASIZE-1:0]  req_addr = '0;
    logic              req_resp, req_done, busy, odata_vld, odata_last;
    logic [2:0]        req_err;
    logic [DSIZE-1:0]  odata;
    logic              odata_ready = 1'b0;
    logic [IDSIZE-1:0] axi_arid;
    logic [ASIZE-1:0]  axi_araddr;
    logic [LSIZE-1:0]  axi_arlen;
    logic [2:0]        axi_arsize, axi_arprot;
    logic [1:0]        axi_arburst;
    logic              axi_arlock, axi_arvalid, axi_rready;
    logic [3:0]        axi_arcache, axi_arqos;
    logic              axi_arready = 1'b0;
    logic [IDSIZE-1:0] axi_rid     = '0;
    logic [DSIZE-1:0]  axi_rdata   = '0;
    logic [1:0]        axi_rresp   = 2'b00;
    logic              axi_rlast   = 1'b0;
    logic              axi_rvalid  = 1'b0;

    axi_inf_read_state_core dut (
        .axi_aclk(axi_aclk), .axi_rst(axi_rst), .read_req(read_req),
        .req_len(req_len), .req_addr(req_addr), .req_resp(req_resp),
        .req_done(req_done), .req_err(req_err), .busy(busy),
        .odata(odata), .odata_vld(odata_vld), .odata_last(odata_last),
        .odata_ready(odata_ready), .axi_arid(axi_arid), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arlock(axi_arlock), .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arqos(axi_arqos), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
        .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 axi_aclk = ~axi_aclk;

    int checks = 0;
    int errors = 0;

    // Observations collected by drive_burst for the test tasks to judge.
    int               n_resp, n_ar, n_done, n_last, last_idx, n_proto;
    logic [ASIZE-1:0] obs_addr;
    logic [LSIZE-1:0] obs_len;
    logic [2:0]       obs_err;
    bit               idle_after, timed_out, abort_zero;
    logic [DSIZE-1:0] sent[$];
    logic [DSIZE-1:0] got[$];

    function automatic logic [DSIZE-1:0] rand_beat();
        logic [DSIZE-1:0] v;
        for (int i = 0; i < DSIZE / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference: number of beats the burst should carry before it ends.
    function automatic int model_beats(input int len, input int rlast_at);
        return (rlast_at <= len) ? rlast_at : len + 1;
    endfunction

    function automatic logic [2:0] model_err(input int len, input int rlast_at,
                                             input int bad_beat, input logic [3:0] rid_v);
        int n;
        logic [2:0] e;
        n = model_beats(len, rlast_at);
        e = 3'b000;
        e[0] = (bad_beat >= 1) && (bad_beat <= n);
        e[1] = (rlast_at != len + 1);
        e[2] = (rid_v != 4'd0);
        return e;
    endfunction

    function automatic int data_bad(input int n);
        int b;
        b = 0;
        for (int i = 0; i < n; i++)
            if (i >= got.size() || i >= sent.size() || got[i] !== sent[i]) b++;
        return b;
    endfunction

    // Acts as requester, AXI slave and stream sink; ready_mode 0=always, 1=toggle, 2=random.
    task automatic drive_burst(input logic [ASIZE-1:0] addr, input int len, input int ar_wait,
                               input int rlast_at, input int bad_beat, input logic [3:0] rid_v,
                               input int ready_mode, input bit extra_req, input int abort_after);
        int arv_cnt;
        int beat;
        bit ar_done, r_hold, in_r, post_done, finished;
        logic [DSIZE-1:0] cur;
        logic exp_rready;
        n_resp = 0; n_ar = 0; n_done = 0; n_last = 0; last_idx = -1; n_proto = 0;
        obs_addr = '0; obs_len = '0; obs_err = '0;
        idle_after = 0; timed_out = 0; abort_zero = 0;
        sent.delete(); got.delete();
        arv_cnt = 0; beat = 0; ar_done = 0; r_hold = 0; in_r = 0; post_done = 0; finished = 0;
        cur = '0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge axi_aclk);
            read_req = (cyc == 0) || (extra_req && cyc >= 2 && n_done == 0);
            req_addr = addr;
            req_len  = LSIZE'(len);
            if (axi_arvalid) arv_cnt++;
            axi_arready = axi_arvalid && (arv_cnt > ar_wait);
            if (ar_done && !r_hold && (ready_mode != 2 || $urandom_range(0, 2) != 0)) begin
                beat++;
                cur = rand_beat();
                sent.push_back(cur);
                r_hold = 1;
            end
            axi_rvalid = r_hold;
            axi_rdata  = r_hold ? cur : '0;
            axi_rlast  = r_hold && (beat == rlast_at);
            axi_rresp  = (r_hold && beat == bad_beat) ? 2'b10 : 2'b00;
            axi_rid    = rid_v;
            case (ready_mode)
                0:       odata_ready = 1'b1;
                1:       odata_ready = (cyc % 2 == 0);
                default: odata_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (post_done) begin
                idle_after = (busy === 1'b0);
                finished = 1;
            end
            if (req_resp === 1'b1) n_resp++;
            if (axi_arvalid && axi_arready) begin
                n_ar++;
                obs_addr = axi_araddr;
                obs_len  = axi_arlen;
                ar_done  = 1;
            end
            exp_rready = in_r ? odata_ready : 1'b0;
            if (axi_rready !== exp_rready) n_proto++;
            if (odata_vld !== (axi_rvalid && axi_rready)) n_proto++;
            if (odata_vld === 1'b1) begin
                got.push_back(odata);
                if (odata_last === 1'b1) begin
                    n_last++;
                    last_idx = got.size() - 1;
                end
                if (axi_rlast || got.size() == len + 1) in_r = 0;
            end
            if (axi_arvalid && axi_arready) in_r = 1;
            if (axi_rvalid && axi_rready) r_hold = 0;
            if (req_done === 1'b1) begin
                n_done++;
                obs_err = req_err;
                post_done = 1;
            end
            if (abort_after > 0 && got.size() == abort_after && !finished) begin
                @(negedge axi_aclk);
                axi_rst = 1'b1;
                #1;
                abort_zero = ({req_resp, req_done, req_err, busy, odata_vld, odata_last,
                               axi_arvalid, axi_rready} === '0) && (odata === '0)
                             && ({axi_araddr, axi_arlen} === '0);
                read_req = 0; axi_rvalid = 0; axi_rlast = 0; axi_arready = 0;
                @(negedge axi_aclk);
                axi_rst = 1'b0;
                repeat (4) begin
                    @(negedge axi_aclk);
                    #1;
                    if (req_done === 1'b1) n_done++;
                end
                finished = 1;
            end
        end
        timed_out = !finished;
        @(negedge axi_aclk);
        read_req = 0; axi_arready = 0; axi_rvalid = 0; axi_rlast = 0;
        axi_rresp = 2'b00; axi_rid = '0; axi_rdata = '0; odata_ready = 0;
        repeat (3) @(negedge axi_aclk);
    endtask

    task automatic test_reset();
        @(negedge axi_aclk);
        axi_rst = 1'b1; read_req = 1'b1; axi_rvalid = 1'b1; odata_ready = 1'b1;
        axi_rdata = rand_beat(); axi_arready = 1'b1;
        #1;
        checks++;
        if ({req_resp, req_done, req_err, busy, odata_vld, odata_last, axi_arvalid,
             axi_rready, axi_arlock, axi_arprot, axi_arqos} !== '0) begin
            errors++; $display("FAIL reset_ctrl_outputs got busy=%0b arvalid=%0b rready=%0b vld=%0b exp all 0",
                               busy, axi_arvalid, axi_rready, odata_vld);
        end
        checks++;
        if (odata !== '0 || axi_araddr !== '0 || axi_arlen !== '0) begin
            errors++; $display("FAIL reset_data_addr got araddr=%0h arlen=%0d exp 0", axi_araddr, axi_arlen);
        end
        checks++;
        if ({axi_arid, axi_arsize, axi_arburst, axi_arcache} !== {4'd0, 3'b101, 2'b01, 4'b0011}) begin
            errors++; $display("FAIL reset_const_fields got id=%0h size=%0b burst=%0b cache=%0b exp 0/101/01/0011",
                               axi_arid, axi_arsize, axi_arburst, axi_arcache);
        end
        read_req = 0; axi_rvalid = 0; odata_ready = 0; axi_arready = 0; axi_rdata = '0;
        @(negedge axi_aclk);
        axi_rst = 1'b0;
        repeat (2) @(negedge axi_aclk);
    endtask

    task automatic test_basic();
        drive_burst(29'h0001_0000, 7, 3, 8, 0, 4'd0, 0, 0, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL basic_timeout got timeout exp done"); end
        checks++;
        if (n_resp !== 1) begin errors++; $display("FAIL basic_resp got %0d exp 1", n_resp); end
        checks++;
        if (n_ar !== 1 || obs_addr !== 29'h0001_0000 || obs_len !== 9'd7) begin
            errors++; $display("FAIL basic_ar got n=%0d addr=%0h len=%0d exp 1/10000/7", n_ar, obs_addr, obs_len);
        end
        checks++;
        if (got.size() !== 8 || data_bad(8) !== 0) begin
            errors++; $display("FAIL basic_data got %0d beats %0d bad exp 8 beats 0 bad", got.size(), data_bad(8));
        end
        checks++;
        if (n_last !== 1 || last_idx !== 7) begin
            errors++; $display("FAIL basic_last got n=%0d idx=%0d exp 1/7", n_last, last_idx);
        end
        checks++;
        if (n_done !== 1 || obs_err !== 3'b000) begin
            errors++; $display("FAIL basic_done got n=%0d err=%0b exp 1/000", n_done, obs_err);
        end
        checks++;
        if (!idle_after || n_proto !== 0) begin
            errors++; $display("FAIL basic_idle_proto got idle=%0b proto=%0d exp 1/0", idle_after, n_proto);
        end
    endtask

    task automatic test_backpressure();
        drive_burst(29'h0001_0000, 7, 0, 8, 0, 4'd0, 1, 0, 0);
        checks++;
        if (timed_out || n_proto !== 0) begin
            errors++; $display("FAIL bp_rready_follow got proto=%0d timeout=%0b exp 0/0", n_proto, timed_out);
        end
        checks++;
        if (got.size() !== 8 || data_bad(8) !== 0) begin
            errors++; $display("FAIL bp_data got %0d beats %0d bad exp 8 beats 0 bad", got.size(), data_bad(8));
        end
        checks++;
        if (n_done !== 1 || obs_err !== 3'b000 || last_idx !== 7) begin
            errors++; $display("FAIL bp_done got n=%0d err=%0b last=%0d exp 1/000/7", n_done, obs_err, last_idx);
        end
    endtask

    task automatic test_len0_slverr();
        drive_burst(29'h0000_0040, 0, 1, 1, 1, 4'd0, 0, 0, 0);
        checks++;
        if (timed_out || got.size() !== 1 || data_bad(1) !== 0) begin
            errors++; $display("FAIL len0_data got %0d beats timeout=%0b exp 1/0", got.size(), timed_out);
        end
        checks++;
        if (n_last !== 1 || last_idx !== 0) begin
            errors++; $display("FAIL len0_last got n=%0d idx=%0d exp 1/0", n_last, last_idx);
        end
        checks++;
        if (n_done !== 1 || obs_err !== 3'b001) begin
            errors++; $display("FAIL len0_err got n=%0d err=%0b exp 1/001", n_done, obs_err);
        end
    endtask

    task automatic test_early_rlast();
        drive_burst(29'h0000_2000, 3, 0, 2, 0, 4'd0, 0, 0, 0);
        checks++;
        if (timed_out || got.size() !== 2 || data_bad(2) !== 0) begin
            errors++; $display("FAIL early_beats got %0d timeout=%0b exp 2/0", got.size(), timed_out);
        end
        checks++;
        if (n_last !== 0) begin errors++; $display("FAIL early_no_last got %0d exp 0", n_last); end
        checks++;
        if (n_done !== 1 || obs_err !== 3'b010) begin
            errors++; $display("FAIL early_err got n=%0d err=%0b exp 1/010", n_done, obs_err);
        end
        checks++;
        if (!idle_after) begin errors++; $display("FAIL early_idle got busy after done exp idle"); end
    endtask

    task automatic test_rid_mismatch();
        drive_burst(29'h0000_3000, 3, 2, 4, 0, 4'd5, 0, 1, 0);
        checks++;
        if (timed_out || n_ar !== 1 || n_resp !== 1) begin
            errors++; $display("FAIL rid_single_ar got ar=%0d resp=%0d exp 1/1", n_ar, n_resp);
        end
        checks++;
        if (n_done !== 1 || obs_err !== 3'b100) begin
            errors++; $display("FAIL rid_err got n=%0d err=%0b exp 1/100", n_done, obs_err);
        end
        checks++;
        if (got.size() !== 4 || data_bad(4) !== 0) begin
            errors++; $display("FAIL rid_data got %0d beats exp 4", got.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        drive_burst(29'h0000_4000, 7, 0, 8, 0, 4'd0, 0, 0, 2);
        checks++;
        if (timed_out || !abort_zero) begin
            errors++; $display("FAIL midrst_outputs got zero=%0b timeout=%0b exp 1/0", abort_zero, timed_out);
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", n_done); end
        drive_burst(29'h0000_5000, 4, 1, 5, 0, 4'd0, 0, 0, 0);
        checks++;
        if (timed_out || n_done !== 1 || obs_err !== 3'b000 || got.size() !== 5 || data_bad(5) !== 0) begin
            errors++; $display("FAIL midrst_recover got done=%0d err=%0b beats=%0d exp 1/000/5",
                               n_done, obs_err, got.size());
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [ASIZE-1:0] a;
            int len, rl, bb, nb;
            logic [3:0] rv;
            logic [2:0] ee;
            a   = ASIZE'($urandom());
            len = $urandom_range(0, 15);
            rl  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 2) : len + 1;
            bb  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, len + 1) : 0;
            rv  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            nb  = model_beats(len, rl);
            ee  = model_err(len, rl, bb, rv);
            drive_burst(a, len, $urandom_range(0, 3), rl, bb, rv, 2, 0, 0);
            checks++;
            if (timed_out || n_ar !== 1 || obs_addr !== a || obs_len !== LSIZE'(len)) begin
                errors++; $display("FAIL rand%0d_ar got addr=%0h len=%0d exp %0h/%0d", t, obs_addr, obs_len, a, len);
            end
            checks++;
            if (got.size() !== nb || data_bad(nb) !== 0 || n_proto !== 0) begin
                errors++; $display("FAIL rand%0d_data got %0d beats proto=%0d exp %0d beats", t, got.size(), n_proto, nb);
            end
            checks++;
            if (n_last !== ((nb == len + 1) ? 1 : 0) || (nb == len + 1 && last_idx !== len)) begin
                errors++; $display("FAIL rand%0d_last got n=%0d idx=%0d exp idx %0d", t, n_last, last_idx, len);
            end
            checks++;
            if (n_done !== 1 || obs_err !== ee || !idle_after) begin
                errors++; $display("FAIL rand%0d_done got n=%0d err=%0b exp 1/%0b", t, n_done, obs_err, ee);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len0_slverr();
        test_early_rlast();
        test_rid_mismatch();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
